icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 29 ++
 rtl/icache_array.sv | 53 +++++
 rtl/icache.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared geometry helpers and FSM state type for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned DEF_SETS  = 32;
    localparam int unsigned DEF_WORDS = 4;

    function automatic int unsigned offset_w(input int unsigned words);
        return $clog2(words);
    endfunction

    function automatic int unsigned index_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    // Byte offset [1:0] is never part of the lookup.
    function automatic int unsigned tag_w(input int unsigned sets, input int unsigned words);
        return 32 - index_w(sets) - offset_w(words) - 2;
    endfunction

    localparam int unsigned OFFSET_W = offset_w(DEF_WORDS);
    localparam int unsigned INDEX_W  = index_w(DEF_SETS);
    localparam int unsigned TAG_W    = tag_w(DEF_SETS, DEF_WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: asynchronous reads, synchronous word and tag writes,
// synchronous clear of all valid bits. Tag and data contents are never reset.
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned SETS  = DEF_SETS,
    parameter int unsigned WORDS = DEF_WORDS,
    parameter int unsigned IW    = index_w(SETS),
    parameter int unsigned OW    = offset_w(WORDS),
    parameter int unsigned TW    = tag_w(SETS, WORDS)
) (
    input  logic          i_clk,
    input  logic          i_clr,
    input  logic [IW-1:0] i_rd_idx,
    input  logic [OW-1:0] i_rd_off,
    output logic          o_rd_valid,
    output logic [TW-1:0] o_rd_tag,
    output logic [31:0]   o_rd_data,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [OW-1:0] i_wr_off,
    input  logic [31:0]   i_wr_data,
    input  logic          i_tv_we,
    input  logic [IW-1:0] i_tv_idx,
    input  logic [TW-1:0] i_tv_tag
);

    logic [SETS-1:0] valid_q;
    logic [TW-1:0]   tag_q  [SETS];
    logic [31:0]     data_q [SETS][WORDS];

    assign o_rd_valid = valid_q[i_rd_idx];
    assign o_rd_tag   = tag_q[i_rd_idx];
    assign o_rd_data  = data_q[i_rd_idx][i_rd_off];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            valid_q <= '0;
        end else if (i_tv_we) begin
            valid_q[i_tv_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_tv_we) begin
            tag_q[i_tv_idx] <= i_tv_tag;
        end
        if (i_wr_en) begin
            data_q[i_wr_idx][i_wr_off] <= i_wr_data;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with zero-cycle hits and a
// one-outstanding-read line fill from backing memory.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned SETS  = DEF_SETS,
    parameter int unsigned WORDS = DEF_WORDS
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_ren,
    input  logic [31:0] i_req_addr,
    output logic        o_req_ready,
    output logic        o_res_valid,
    output logic [31:0] o_res_rdata,
    output logic        o_mem_ren,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned OW = offset_w(WORDS);
    localparam int unsigned IW = index_w(SETS);
    localparam int unsigned TW = tag_w(SETS, WORDS);
    localparam int unsigned CW = OW + 1;
    localparam logic [CW-1:0] FULL = CW'(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] tag_q, tag_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] issue_q, issue_d;
    logic [CW-1:0] recv_q, recv_d;
    logic          outst_q, outst_d;

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [OW-1:0] req_off;
    logic          unused_addr_bits;

    logic          rd_valid;
    logic [TW-1:0] rd_tag;
    logic          hit;
    logic          issue_fire;
    logic          wr_en;
    logic          tv_we;

    assign req_tag          = i_req_addr[31 -: TW];
    assign req_idx          = i_req_addr[2 + OW +: IW];
    assign req_off          = i_req_addr[2 +: OW];
    assign unused_addr_bits = ^i_req_addr[1:0];

    assign hit        = rd_valid && (rd_tag == req_tag);
    assign o_mem_addr = {tag_q, idx_q, issue_q[OW-1:0], 2'b00};

    icache_array #(
        .SETS  (SETS),
        .WORDS (WORDS)
    ) u_array (
        .i_clk      (i_clk),
        .i_clr      (i_rst),
        .i_rd_idx   (req_idx),
        .i_rd_off   (req_off),
        .o_rd_valid (rd_valid),
        .o_rd_tag   (rd_tag),
        .o_rd_data  (o_res_rdata),
        .i_wr_en    (wr_en),
        .i_wr_idx   (idx_q),
        .i_wr_off   (recv_q[OW-1:0]),
        .i_wr_data  (i_mem_rdata),
        .i_tv_we    (tv_we),
        .i_tv_idx   (idx_q),
        .i_tv_tag   (tag_q)
    );

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        idx_d       = idx_q;
        issue_d     = issue_q;
        recv_d      = recv_q;
        outst_d     = outst_q;
        o_req_ready = 1'b0;
        o_res_valid = 1'b0;
        o_mem_ren   = 1'b0;
        issue_fire  = 1'b0;
        wr_en       = 1'b0;
        tv_we       = 1'b0;

        unique case (state_q)
            IDLE: begin
                o_req_ready = !(i_req_ren && !hit);
                o_res_valid = i_req_ren && hit;
                if (i_req_ren && !hit) begin
                    state_d = FILL;
                    tag_d   = req_tag;
                    idx_d   = req_idx;
                    issue_d = '0;
                    recv_d  = '0;
                    outst_d = 1'b0;
                end
            end
            FILL: begin
                o_mem_ren  = !outst_q && (issue_q < FULL);
                issue_fire = o_mem_ren && i_mem_ready;
                if (issue_fire) begin
                    issue_d = issue_q + CW'(1);
                    outst_d = 1'b1;
                end
                // A response closes the outstanding read, even one accepted this cycle.
                if (i_mem_valid) begin
                    wr_en   = 1'b1;
                    recv_d  = recv_q + CW'(1);
                    outst_d = 1'b0;
                    if (recv_q == LAST) begin
                        tv_we   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            issue_q <= '0;
            recv_q  <= '0;
            outst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
            outst_q <= outst_d;
        end
    end

    always_ff @(posedge i_clk) begin
        tag_q <= tag_d;
        idx_q <= idx_d;
    end

endmodule
